sn74ls148_irq: RTL and testbench

SN74LS148_IRQ -- requirements
Module: sn74ls148_irq

---
 rtl/sn74ls148_irq.sv | 107 ++++++++++
 tb/tb_sn74ls148_irq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sn74ls148_irq.sv
// sn74ls148_irq: registered 8-level priority interrupt encoder in the style of
// the 74LS148. Requests latch into a pending register, the highest pending
// index is presented as an active-low code until acknowledged, and repeat
// requests on an already-pending line raise a sticky overrun flag.
module sn74ls148_irq (
    input  logic CLK,
    input  logic RST,
    input  logic EI_N,
    input  logic I0_N,
    input  logic I1_N,
    input  logic I2_N,
    input  logic I3_N,
    input  logic I4_N,
    input  logic I5_N,
    input  logic I6_N,
    input  logic I7_N,
    input  logic ACK,
    output logic A0_N,
    output logic A1_N,
    output logic A2_N,
    output logic GS_N,
    output logic EO_N,
    output logic OVR
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t      state_q, state_d;
    logic [7:0]  req;
    logic [7:0]  pend_q, pend_d;
    logic [7:0]  clr;
    logic [2:0]  code_q, code_d;
    logic        ovr_d;

    assign req = ~{I7_N, I6_N, I5_N, I4_N, I3_N, I2_N, I1_N, I0_N};

    // Index of the highest set bit; later (higher) indices overwrite lower ones.
    function automatic logic [2:0] top_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Next-state, code capture, pending update and overrun detection.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        clr     = 8'd0;
        // A disabled encoder drops back to IDLE and keeps everything pending;
        // an ACK on that same edge is not honoured.
        if (EI_N) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    // Arbitrate on the registered pending set only, so a request
                    // is presented one edge after it was latched.
                    if (pend_q != 8'd0) begin
                        state_d = HOLD;
                        code_d  = top_index(pend_q);
                    end
                end
                HOLD: begin
                    if (ACK) begin
                        state_d = IDLE;
                        clr     = 8'd1 << code_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        // The acknowledge clear wins over a same-edge request on that line.
        pend_d = (pend_q | req) & ~clr;
        ovr_d  = OVR | (|(req & pend_q & ~clr));
    end

    // State, pending, code and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q              <= IDLE;
            pend_q               <= 8'd0;
            code_q               <= 3'd0;
            OVR                  <= 1'b0;
            {A2_N, A1_N, A0_N}   <= 3'b111;
            GS_N                 <= 1'b1;
            EO_N                 <= 1'b1;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            code_q  <= code_d;
            OVR     <= ovr_d;
            if (state_d == HOLD) begin
                {A2_N, A1_N, A0_N} <= ~code_d;
                GS_N               <= 1'b0;
                EO_N               <= 1'b1;
            end else begin
                {A2_N, A1_N, A0_N} <= 3'b111;
                GS_N               <= 1'b1;
                EO_N               <= ~(~EI_N & (pend_d == 8'd0));
            end
        end
    end

endmodule

// File: tb/tb_sn74ls148_irq.sv
// tb_sn74ls148_irq: directed scenarios plus randomized traffic, every edge
// compared against a behavioural model of the priority encoder.
module tb_sn74ls148_irq;

    logic       CLK = 1'b0;
    logic       RST;
    logic       EI_N;
    logic [7:0] i_n;
    logic       ACK;
    logic       A0_N, A1_N, A2_N, GS_N, EO_N, OVR;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    bit         mp [8];
    bit         mhold;
    int         mcode;
    bit         movr;
    bit         m_ei_low;

    sn74ls148_irq dut (
        .CLK (CLK),
        .RST (RST),
        .EI_N(EI_N),
        .I0_N(i_n[0]),
        .I1_N(i_n[1]),
        .I2_N(i_n[2]),
        .I3_N(i_n[3]),
        .I4_N(i_n[4]),
        .I5_N(i_n[5]),
        .I6_N(i_n[6]),
        .I7_N(i_n[7]),
        .ACK (ACK),
        .A0_N(A0_N),
        .A1_N(A1_N),
        .A2_N(A2_N),
        .GS_N(GS_N),
        .EO_N(EO_N),
        .OVR (OVR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock edge of the reference behaviour.
    task automatic model_edge(input bit r, input bit ei, input logic [7:0] rq, input bit ak);
        int winner;
        int cleared;
        if (r) begin
            for (int i = 0; i < 8; i++) mp[i] = 0;
            mhold = 0; mcode = 0; movr = 0; m_ei_low = 0;
            return;
        end
        winner  = -1;
        cleared = -1;
        if (ei) begin
            mhold = 0;
        end else if (!mhold) begin
            for (int i = 7; i >= 0; i--)
                if (mp[i] && winner < 0) winner = i;
            if (winner >= 0) begin
                mhold = 1;
                mcode = winner;
            end
        end else if (ak) begin
            cleared = mcode;
            mhold   = 0;
        end
        for (int i = 0; i < 8; i++) begin
            if (rq[i] && mp[i] && i != cleared) movr = 1;
            mp[i] = (mp[i] || rq[i]) && (i != cleared);
        end
        m_ei_low = !ei;
    endtask

    task automatic compare_all();
        logic [2:0] ea;
        bit         egs, eeo, any;
        any = 0;
        for (int i = 0; i < 8; i++) any = any | mp[i];
        if (mhold) begin
            ea  = 3'(7 - mcode);
            egs = 0;
            eeo = 1;
        end else begin
            ea  = 3'b111;
            egs = 1;
            eeo = !(m_ei_low && !any);
        end
        check("a_n",  {5'd0, A2_N, A1_N, A0_N}, {5'd0, ea});
        check("gs_n", {7'd0, GS_N}, {7'd0, egs});
        check("eo_n", {7'd0, EO_N}, {7'd0, eeo});
        check("ovr",  {7'd0, OVR},  {7'd0, movr});
    endtask

    // Apply inputs, clock one edge, then compare one time unit later.
    task automatic step(input bit r, input bit ei, input logic [7:0] rq, input bit ak);
        RST  = r;
        EI_N = ei;
        i_n  = ~rq;
        ACK  = ak;
        @(posedge CLK);
        model_edge(r, ei, rq, ak);
        #1;
        compare_all();
    endtask

    function automatic logic [7:0] a_val();
        return {5'd0, A2_N, A1_N, A0_N};
    endfunction

    initial begin
        bit found;
        RST = 1'b1; EI_N = 1'b1; i_n = 8'hFF; ACK = 1'b0;

        // Reset values
        step(1, 1, 8'h00, 0);
        check("rst_a_n", a_val(), 8'h07);
        check("rst_gs",  {7'd0, GS_N}, 8'h01);
        check("rst_eo",  {7'd0, EO_N}, 8'h01);
        check("rst_ovr", {7'd0, OVR},  8'h00);

        // Basic encode of line 5
        step(0, 0, 8'h20, 0);
        step(0, 0, 8'h00, 0);
        check("enc5_a_n", a_val(), 8'h02);
        check("enc5_gs",  {7'd0, GS_N}, 8'h00);
        step(0, 0, 8'h00, 1);
        check("enc5_ack_gs", {7'd0, GS_N}, 8'h01);
        check("enc5_ack_eo", {7'd0, EO_N}, 8'h00);

        // Priority: 6 before 2
        step(0, 0, 8'h44, 0);
        step(0, 0, 8'h00, 0);
        check("pri_a6", a_val(), 8'h01);
        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0);
        check("pri_a2", a_val(), 8'h05);
        step(0, 0, 8'h00, 1);

        // Disabled encoder keeps the request pending
        step(0, 1, 8'h08, 0);
        check("dis_gs", {7'd0, GS_N}, 8'h01);
        check("dis_eo", {7'd0, EO_N}, 8'h01);
        step(0, 0, 8'h00, 0);
        check("dis_a3", a_val(), 8'h04);
        step(0, 0, 8'h00, 1);

        // Freeze in HOLD against a higher-priority arrival
        step(0, 0, 8'h02, 0);
        step(0, 0, 8'h00, 0);
        check("frz_a1", a_val(), 8'h06);
        step(0, 0, 8'h80, 0);
        step(0, 0, 8'h00, 0);
        check("frz_a1_kept", a_val(), 8'h06);
        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0);
        check("frz_a7", a_val(), 8'h00);
        step(0, 0, 8'h00, 1);

        // Overrun from a held line, then reset during HOLD
        step(0, 0, 8'h10, 0);
        step(0, 0, 8'h10, 0);
        step(0, 0, 8'h10, 0);
        check("ovr_set", {7'd0, OVR}, 8'h01);
        check("ovr_hold_gs", {7'd0, GS_N}, 8'h00);
        step(1, 0, 8'h00, 0);
        check("ovr_rst_ovr", {7'd0, OVR}, 8'h00);
        check("ovr_rst_gs",  {7'd0, GS_N}, 8'h01);
        step(0, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);
        check("ovr_no_code", {7'd0, GS_N}, 8'h01);

        // Same-edge clear with line 0 held low
        step(0, 0, 8'h01, 0);
        step(0, 0, 8'h01, 0);
        check("sec_gs", {7'd0, GS_N}, 8'h00);
        step(0, 0, 8'h01, 1);
        check("sec_ack_gs", {7'd0, GS_N}, 8'h01);
        found = 0;
        for (int k = 0; k < 4 && !found; k++) begin
            step(0, 0, 8'h01, 0);
            if (GS_N == 1'b0) found = 1;
        end
        check("sec_represent", {7'd0, found}, 8'h01);
        check("sec_a0", a_val(), 8'h07);
        step(1, 0, 8'h00, 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] rq;
            bit r, ei, ak;
            rq = 8'd0;
            for (int b = 0; b < 8; b++)
                if ($urandom_range(0, 9) == 0) rq[b] = 1'b1;
            r  = ($urandom_range(0, 149) == 0);
            ei = ($urandom_range(0, 9) == 0);
            ak = ($urandom_range(0, 2) == 0);
            step(r, ei, rq, ak);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
